// File: rtl/shift_unit_seq_pkg.sv
// rtl/shift_unit_seq_pkg.sv - shared ALU shift encodings and width helper
package shift_unit_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } shift_state_e;

  // ceil(log2(value)), 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate by 0..STEP positions
module shift_step
  import shift_unit_seq_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4,
  localparam int SW  = clog2(STEP) + 1
) (
  input  logic [N-1:0]  din,
  input  shift_op_e     op,
  input  logic [SW-1:0] amt,
  output logic [N-1:0]  dout
);

  logic [2*N-1:0] rot;

  // rotating the doubled word right keeps bits leaving the LSB in the upper half
  assign rot = {din, din} >> amt;

  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = din << amt;
      OP_SRL:  dout = din >> amt;
      OP_SRA:  dout = $unsigned($signed(din) >>> amt);
      OP_ROR:  dout = rot[N-1:0];
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - iterative multi-cycle shift/rotate unit with start/valid handshake
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] res
);

  localparam int AW = clog2(N);
  localparam int RW = AW + 1;
  localparam int SW = clog2(STEP) + 1;

  shift_state_e  state, next_state;
  shift_op_e     op_q;
  logic [N-1:0]  work;
  logic [N-1:0]  shifted;
  logic [RW-1:0] rem;
  logic [SW-1:0] step_amt;
  logic          last;
  logic          accept;
  logic          done;
  logic          unused_in2;

  assign unused_in2 = ^in2[N-1:AW];

  assign last     = (rem <= RW'(STEP));
  assign step_amt = last ? SW'(rem) : SW'(STEP);

  shift_step #(
    .N    (N),
    .STEP (STEP)
  ) u_step (
    .din  (work),
    .op   (op_q),
    .amt  (step_amt),
    .dout (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (last)  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ST_RUN);
    accept = (state == ST_IDLE) && start;
    done   = (state == ST_RUN) && last;
  end

  // inputs are captured only on acceptance; the RUN loop works purely on the copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      op_q  <= OP_SLL;
      rem   <= '0;
      res   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= done;
      if (accept) begin
        work <= in1;
        op_q <= shift_op_e'(op);
        rem  <= {1'b0, in2[AW-1:0]};
      end else if (busy) begin
        work <= shifted;
        rem  <= last ? '0 : rem - RW'(STEP);
      end
      if (done) res <= shifted;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - directed self-checking bench for shift_unit_seq at STEP 1, 4 and 32
module tb_shift_unit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        b1, v1, b4, v4, b32, v32;
  logic [31:0] r1, r4, r32;

  int errors;
  int checks;

  shift_unit_seq #(.N(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(b1), .valid(v1), .res(r1)
  );
  shift_unit_seq #(.N(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(b4), .valid(v4), .res(r4)
  );
  shift_unit_seq #(.N(32), .STEP(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(b32), .valid(v32), .res(r32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] golden(input int o, input logic [31:0] d, input int a);
    case (o)
      0:       return d << a;
      1:       return d >> a;
      2:       return $unsigned($signed(d) >>> a);
      default: return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
    endcase
  endfunction

  function automatic int exp_lat(input int a, input int s);
    return (a == 0) ? 1 : (a + s - 1) / s;
  endfunction

  task automatic launch(input int o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = 2'(o);
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (1) begin
      if (b4) bc++;
      @(posedge clk);
      #1;
      lat++;
      if (v4) break;
      if (lat >= 100) begin
        lat = -1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, cnt;
    int steps[3];
    int lats[3];
    logic [31:0] rr[3];
    logic [31:0] d, e;

    errors = 0;
    checks = 0;
    steps  = '{1, 4, 32};
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    in1   = '0;
    in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(b4), 32'd0);
    check("reset_valid", 32'(v4), 32'd0);
    check("reset_res", r4, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(0, 32'h0000_0001, 32'd31);
    wait_valid(lat, bc);
    check("sll_lat", 32'(lat), 32'd8);
    check("sll_res", r4, 32'h8000_0000);
    check("sll_busy_cycles", 32'(bc), 32'd8);
    check("sll_busy_at_valid", 32'(b4), 32'd0);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 32'(v4), 32'd0);
    check("res_held", r4, 32'h8000_0000);

    launch(0, 32'h0000_0001, 32'd31);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(b4), 32'd0);
    check("abort_valid", 32'(v4), 32'd0);
    check("abort_res", r4, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (v4) cnt++;
    end
    check("abort_no_valid", 32'(cnt), 32'd0);

    launch(2, 32'h8000_00F0, 32'hFFFF_FFE4);
    wait_valid(lat, bc);
    check("sra_lat", 32'(lat), 32'd1);
    check("sra_res", r4, 32'hF800_000F);

    launch(3, 32'h1234_5678, 32'd8);
    wait_valid(lat, bc);
    check("ror_lat", 32'(lat), 32'd2);
    check("ror_res", r4, 32'h7812_3456);
    launch(1, 32'h1234_5678, 32'd0);
    check("b2b_accept", 32'(b4), 32'd1);
    wait_valid(lat, bc);
    check("b2b_lat", 32'(lat), 32'd1);
    check("b2b_res", r4, 32'h1234_5678);

    launch(1, 32'hF000_0000, 32'd12);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    in1   = 32'hFFFF_FFFF;
    in2   = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(lat, bc);
    if (lat > 0) lat += 2;
    check("busy_start_lat", 32'(lat), 32'd3);
    check("busy_start_res", r4, 32'h000F_0000);
    @(posedge clk);
    #1;
    check("busy_start_no_rerun", 32'(b4), 32'd0);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 32; a++) begin
        d = $urandom;
        e = golden(o, d, a);
        launch(o, d, ($urandom & 32'hFFFF_FFE0) | 32'(a));
        lats = '{-1, -1, -1};
        for (int c = 1; c <= 40; c++) begin
          @(posedge clk);
          #1;
          if (v1 && lats[0] < 0) begin lats[0] = c; rr[0] = r1; end
          if (v4 && lats[1] < 0) begin lats[1] = c; rr[1] = r4; end
          if (v32 && lats[2] < 0) begin lats[2] = c; rr[2] = r32; end
        end
        for (int i = 0; i < 3; i++) begin
          check($sformatf("sweep_lat s%0d op%0d amt%0d", steps[i], o, a),
                32'(lats[i]), 32'(exp_lat(a, steps[i])));
          if (lats[i] > 0)
            check($sformatf("sweep_res s%0d op%0d amt%0d", steps[i], o, a), rr[i], e);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
